bcd_up_down_counter: RTL and testbench
======================================

Name: bcd_up_down_counter

Overview:
- Multi-digit packed-BCD up/down counter, directly downstream of the single-pulser stage on the Basys3 board.
- Consumes the one-cycle pulses produced from debounced push-buttons and counts them.
- Drives a packed BCD value for the display stage, plus carry/borrow pulses for cascading.

Parameters:
- NUM_DIGITS, 2, number of BCD digits; Count width is 4*NUM_DIGITS; legal range 1..8.
- WRAP, 1, 1 = wrap at the ends (max->0 up, 0->max down); 0 = saturate at 0 and at max.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- UpPulse  in  1  count-up request; one request per cycle it is high.
- DownPulse  in  1  count-down request; one request per cycle it is high.
- LoadEn  in  1  synchronous load strobe.
- LoadValue  in  4*NUM_DIGITS  packed BCD value to load; digit 0 in bits [3:0].
- Count  out  4*NUM_DIGITS  registered packed BCD count; digit 0 = least significant.
- Carry  out  1  registered one-cycle pulse on an upward wrap from max to 0.
- Borrow  out  1  registered one-cycle pulse on a downward wrap from 0 to max.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset low: Count=0, Carry=0, Borrow=0 immediately, independent of Clk. Hold while low; normal operation starts at the first rising edge after release.
- All outputs are registered. Latency is 1 cycle: a request sampled at edge N is visible on Count after edge N.
- Per-edge priority:
  - LoadEn=1: Count <= LoadValue. Any digit greater than 9 is clamped to 9. Up/Down are ignored. Carry=0, Borrow=0.
  - Else UpPulse=1 and DownPulse=1: Count is held. Carry=0, Borrow=0.
  - Else UpPulse=1: increment.
  - Else DownPulse=1: decrement.
  - Else: hold.
- Increment: ripple per digit. A digit equal to 9 becomes 0 and carries into the next digit; otherwise the digit is incremented by 1 and the ripple stops.
- Decrement: a digit equal to 0 becomes 9 and borrows from the next digit; otherwise the digit is decremented by 1 and the ripple stops.
- Max value means every digit = 9, e.g. 8'h99 for NUM_DIGITS=2.
- WRAP=1:
  - Up at max: Count <= 0, Carry=1 for exactly that one cycle.
  - Down at 0: Count <= max, Borrow=1 for one cycle.
- WRAP=0:
  - Up at max and Down at 0 are ignored.
  - Carry and Borrow are never asserted.
- Carry and Borrow return to 0 on the next edge unless a new wrap occurs on that edge. Consecutive wraps give consecutive pulses.
- No edge detection on inputs: UpPulse held high for K cycles produces K increments (edge detection is the pulser's job).
- Count never holds a non-BCD digit under any input sequence.
- Reset asserted mid-operation overrides everything, including a load or a wrap in the same cycle.

Optional Feature:
- Macro: BCD_COUNTER_HOLD_EN.
- Defined: an extra input port Hold (1 bit, after DownPulse).
  - While Hold=1, UpPulse and DownPulse are ignored and Count holds.
  - LoadEn still works; Carry=0 and Borrow=0.
- Not defined: no Hold port; behaviour exactly as above.

Test Plan:
- Drive Reset=0 for 3 cycles, with UpPulse=1 throughout -> Count=8'h00, Carry=0, Borrow=0. Release Reset with no requests for 5 cycles -> Count stays 8'h00.
- Apply 10 single-cycle UpPulse from 8'h00 -> Count steps 01..09 then 8'h10; Carry never 1. Hold UpPulse high 3 cycles -> 8'h13.
- Load 8'h99, then one UpPulse -> Count=8'h00 and Carry=1 for exactly one cycle. Then one DownPulse -> 8'h99 and Borrow=1 for one cycle. Then one DownPulse -> 8'h98, Borrow=0.
- At 8'h45, UpPulse=DownPulse=1 -> stays 8'h45. LoadEn=1 with LoadValue=8'h3C and UpPulse=1 -> Count=8'h39 (load wins, digit clamped).
- WRAP=0: load 8'h99, UpPulse -> stays 8'h99, Carry=0. Load 8'h00, DownPulse -> stays 8'h00, Borrow=0.
- Count up to 8'h27, assert Reset mid-cycle between edges -> Count=8'h00 before the next edge. With BCD_COUNTER_HOLD_EN and Hold=1, 4 UpPulse -> Count unchanged.

Source files
------------

// File: rtl/bcd_up_down_counter.sv
// Packed-BCD up/down counter with load, wrap/saturate ends and carry/borrow pulses.
// Optional Hold input enabled by defining BCD_COUNTER_HOLD_EN.
module bcd_up_down_counter #(
   parameter int NUM_DIGITS = 2,
   parameter int WRAP       = 1
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    UpPulse,
   input  logic                    DownPulse,
`ifdef BCD_COUNTER_HOLD_EN
   input  logic                    Hold,
`endif
   input  logic                    LoadEn,
   input  logic [4*NUM_DIGITS-1:0] LoadValue,
   output logic [4*NUM_DIGITS-1:0] Count,
   output logic                    Carry,
   output logic                    Borrow
);

   localparam int W = 4 * NUM_DIGITS;

   logic [W-1:0]        r_count;
   logic                r_carry;
   logic                r_borrow;
   logic [W-1:0]        w_inc;
   logic [W-1:0]        w_dec;
   logic [W-1:0]        w_load;
   logic [NUM_DIGITS:0] w_inc_ripple;
   logic [NUM_DIGITS:0] w_dec_ripple;
   logic                w_hold;
   logic                w_at_max;
   logic                w_at_zero;

`ifdef BCD_COUNTER_HOLD_EN
   assign w_hold = Hold;
`else
   assign w_hold = 1'b0;
`endif

   assign w_inc_ripple[0] = 1'b1;
   assign w_dec_ripple[0] = 1'b1;

   // Ripple chains: a digit only changes when every lower digit rolled over.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         logic [3:0] w_d;
         logic [3:0] w_lv;
         assign w_d  = r_count[4*gi +: 4];
         assign w_lv = LoadValue[4*gi +: 4];

         assign w_inc[4*gi +: 4] = !w_inc_ripple[gi] ? w_d :
                                   (w_d == 4'd9)     ? 4'd0 : w_d + 4'd1;
         assign w_inc_ripple[gi+1] = w_inc_ripple[gi] & (w_d == 4'd9);

         assign w_dec[4*gi +: 4] = !w_dec_ripple[gi] ? w_d :
                                   (w_d == 4'd0)     ? 4'd9 : w_d - 4'd1;
         assign w_dec_ripple[gi+1] = w_dec_ripple[gi] & (w_d == 4'd0);

         assign w_load[4*gi +: 4] = (w_lv > 4'd9) ? 4'd9 : w_lv;
      end
   endgenerate

   // All digits 9 ripples a carry out of the top; all digits 0 ripples a borrow.
   assign w_at_max  = w_inc_ripple[NUM_DIGITS];
   assign w_at_zero = w_dec_ripple[NUM_DIGITS];

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_count  <= '0;
         r_carry  <= 1'b0;
         r_borrow <= 1'b0;
      end else begin
         r_carry  <= 1'b0;
         r_borrow <= 1'b0;
         if (LoadEn) begin
            r_count <= w_load;
         end else if (w_hold || (UpPulse && DownPulse)) begin
            r_count <= r_count;
         end else if (UpPulse) begin
            if (!w_at_max) begin
               r_count <= w_inc;
            end else if (WRAP != 0) begin
               r_count <= w_inc;
               r_carry <= 1'b1;
            end
         end else if (DownPulse) begin
            if (!w_at_zero) begin
               r_count <= w_dec;
            end else if (WRAP != 0) begin
               r_count  <= w_dec;
               r_borrow <= 1'b1;
            end
         end
      end
   end

   assign Count  = r_count;
   assign Carry  = r_carry;
   assign Borrow = r_borrow;

endmodule

// File: tb/tb_bcd_up_down_counter.sv
// Scoreboard bench for bcd_up_down_counter: a wrapping and a saturating instance
// driven in parallel and compared against a decimal-arithmetic reference model.
module tb_bcd_up_down_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       up_i, dn_i, ld_i, hold_i;
   logic [7:0] lv_i;
   logic [7:0] cnt_w, cnt_s;
   logic       cy_w, cy_s, bw_w, bw_s;

   int n_checks = 0;
   int n_errors = 0;

   logic [9:0] exp_q_w[$];
   logic [9:0] exp_q_s[$];
   logic [7:0] m_w, m_s;

   always #5 clk = ~clk;

   bcd_up_down_counter #(.NUM_DIGITS(2), .WRAP(1)) dut_wrap (
      .Clk(clk), .Reset(rst_n), .UpPulse(up_i), .DownPulse(dn_i),
`ifdef BCD_COUNTER_HOLD_EN
      .Hold(hold_i),
`endif
      .LoadEn(ld_i), .LoadValue(lv_i), .Count(cnt_w), .Carry(cy_w), .Borrow(bw_w)
   );

   bcd_up_down_counter #(.NUM_DIGITS(2), .WRAP(0)) dut_sat (
      .Clk(clk), .Reset(rst_n), .UpPulse(up_i), .DownPulse(dn_i),
`ifdef BCD_COUNTER_HOLD_EN
      .Hold(hold_i),
`endif
      .LoadEn(ld_i), .LoadValue(lv_i), .Count(cnt_s), .Carry(cy_s), .Borrow(bw_s)
   );

   task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got count=%h carry=%b borrow=%b expected count=%h carry=%b borrow=%b",
                  tag, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
      end
   endtask

   // Returns {count, carry, borrow}; arithmetic done in decimal, not per digit.
   function automatic logic [9:0] model(input logic [7:0] cur, input logic up, dn, ld, hold,
                                        input logic [7:0] lv, input int wrap);
      int v;
      logic [3:0] d0, d1;
      if (ld) begin
         d0 = lv[3:0];
         d1 = lv[7:4];
         if (d0 > 4'd9) d0 = 4'd9;
         if (d1 > 4'd9) d1 = 4'd9;
         return {d1, d0, 2'b00};
      end
      if (hold || (up == dn)) return {cur, 2'b00};
      v = int'(cur[7:4]) * 10 + int'(cur[3:0]);
      if (up) begin
         if (v == 99) return (wrap != 0) ? {8'h00, 2'b10} : {cur, 2'b00};
         v = v + 1;
      end else begin
         if (v == 0) return (wrap != 0) ? {8'h99, 2'b01} : {cur, 2'b00};
         v = v - 1;
      end
      return {4'(v / 10), 4'(v % 10), 2'b00};
   endfunction

   task automatic step(input string tag, input logic up, dn, ld, input logic [7:0] lv);
      logic [9:0] e;
      @(negedge clk);
      up_i = up; dn_i = dn; ld_i = ld; lv_i = lv;
      e = model(m_w, up, dn, ld, hold_i, lv, 1);
      exp_q_w.push_back(e);
      m_w = e[9:2];
      e = model(m_s, up, dn, ld, hold_i, lv, 0);
      exp_q_s.push_back(e);
      m_s = e[9:2];
      @(posedge clk);
      #1;
      check({tag, "_wrap"}, {cnt_w, cy_w, bw_w}, exp_q_w.pop_front());
      check({tag, "_sat"},  {cnt_s, cy_s, bw_s}, exp_q_s.pop_front());
      $display("step %-10s up=%b dn=%b ld=%b lv=%h -> wrap %h/%b%b sat %h/%b%b",
               tag, up, dn, ld, lv, cnt_w, cy_w, bw_w, cnt_s, cy_s, bw_s);
   endtask

   initial begin
      rst_n = 1'b0; up_i = 1'b1; dn_i = 1'b0; ld_i = 1'b0; hold_i = 1'b0; lv_i = 8'h00;
      m_w = 8'h00; m_s = 8'h00;
      #1;
      check("rst_async", {cnt_w, cy_w, bw_w}, 10'h000);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("rst_hold", {cnt_w, cy_w, bw_w}, 10'h000);
         check("rst_hold_sat", {cnt_s, cy_s, bw_s}, 10'h000);
      end
      @(negedge clk);
      up_i = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step("idle", 0, 0, 0, 8'h00);

      for (int i = 0; i < 10; i++) begin
         step("up1", 1, 0, 0, 8'h00);
         step("gap", 0, 0, 0, 8'h00);
      end
      check("cnt_10", {cnt_w, cy_w, bw_w}, {8'h10, 2'b00});
      for (int i = 0; i < 3; i++) step("uphold", 1, 0, 0, 8'h00);
      check("cnt_13", {cnt_w, cy_w, bw_w}, {8'h13, 2'b00});

      step("ld99", 0, 0, 1, 8'h99);
      step("upwrap", 1, 0, 0, 8'h00);
      check("carry_pulse", {cnt_w, cy_w, bw_w}, {8'h00, 2'b10});
      step("dnwrap", 0, 1, 0, 8'h00);
      check("borrow_pulse", {cnt_w, cy_w, bw_w}, {8'h99, 2'b01});
      step("dn", 0, 1, 0, 8'h00);
      check("cnt_98", {cnt_w, cy_w, bw_w}, {8'h98, 2'b00});

      step("ld45", 0, 0, 1, 8'h45);
      step("updn", 1, 1, 0, 8'h00);
      step("ldclamp", 1, 0, 1, 8'h3C);
      check("clamp_39", {cnt_w, cy_w, bw_w}, {8'h39, 2'b00});
      step("ldclamp2", 0, 1, 1, 8'hFA);

      step("ld99", 0, 0, 1, 8'h99);
      step("upmax", 1, 0, 0, 8'h00);
      check("sat_max", {cnt_s, cy_s, bw_s}, {8'h99, 2'b00});
      step("ld00", 0, 0, 1, 8'h00);
      step("dnzero", 0, 1, 0, 8'h00);
      check("sat_zero", {cnt_s, cy_s, bw_s}, {8'h00, 2'b00});
      step("dnzero2", 0, 1, 0, 8'h00);

      for (int i = 0; i < 200; i++) begin
         step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 15) == 0), 8'($urandom));
      end

      step("ld20", 0, 0, 1, 8'h20);
      for (int i = 0; i < 7; i++) step("to27", 1, 0, 0, 8'h00);
      check("cnt_27", {cnt_w, cy_w, bw_w}, {8'h27, 2'b00});
      #2;
      up_i = 1'b1;
      rst_n = 1'b0;
      #1;
      check("rst_mid", {cnt_w, cy_w, bw_w}, 10'h000);
      check("rst_mid_sat", {cnt_s, cy_s, bw_s}, 10'h000);
      m_w = 8'h00; m_s = 8'h00;
      @(posedge clk);
      #1;
      check("rst_mid_edge", {cnt_w, cy_w, bw_w}, 10'h000);
      @(negedge clk);
      up_i = 1'b0;
      rst_n = 1'b1;
      step("after_rst", 1, 0, 0, 8'h00);

`ifdef BCD_COUNTER_HOLD_EN
      hold_i = 1'b1;
      for (int i = 0; i < 4; i++) step("hold_up", 1, 0, 0, 8'h00);
      check("hold_cnt", {cnt_w, cy_w, bw_w}, {8'h01, 2'b00});
      step("hold_ld", 1, 0, 1, 8'h57);
      step("hold_dn", 0, 1, 0, 8'h00);
      hold_i = 1'b0;
      step("unhold", 0, 1, 0, 8'h00);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
